tug_of_war_ctrl: RTL and testbench
==================================

Name: tug_of_war_ctrl

Overview:
- Game controller for the tug-of-war light row: the row of normal lights plus two end lights.
- Edge-detects the two player keys and arbitrates simultaneous presses into single-cycle move pulses for the row.
- Detects a point won at either end, keeps per-player scores and clears the playfield between rounds.
- Declares the match winner once a score reaches WIN_SCORE.

Parameters:
- SCORE_W, 3, width of each score counter.
- WIN_SCORE, 7, score that ends the match. Must be ≤ 2^SCORE_W − 1.
- HOLD_CYCLES, 4, cycles the point winner is displayed before the field is cleared. Must be ≥ 1.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- key_L  in  1  left player key, level, already synchronized, 1 = pressed.
- key_R  in  1  right player key, level, already synchronized, 1 = pressed.
- left_end_on  in  1  leftmost light is lit.
- right_end_on  in  1  rightmost light is lit.
- L  out  1  one-cycle left-move pulse to the row.
- R  out  1  one-cycle right-move pulse to the row.
- field_reset  out  1  clears the light row (drives the lights' Reset).
- score_L  out  SCORE_W  left player score.
- score_R  out  SCORE_W  right player score.
- winner  out  2  00 = none, 01 = left, 10 = right; never 11.
- match_over  out  1  match finished.

Behaviour:
- Reset is synchronous and active-high. In any cycle with Reset = 1:
  - state <= CLEAR, scores <= 0, key history <= 0, hold counter <= 0.
  - field_reset = 1 combinationally.
  - L = R = 0, winner = 00, match_over = 0.
- Press detection:
  - pL = key_L & ~key_L_q and pR = key_R & ~key_R_q, where _q is the key registered on the previous cycle.
  - A held key gives one press only.
- Arbitration, in PLAY only:
  - pL & ~pR → L = 1.
  - pR & ~pL → R = 1.
  - pL & pR in the same cycle → both suppressed, L = R = 0.
  - L and R are combinational from state and presses; move latency is 0 cycles from the press edge cycle.
- States:
  - CLEAR
    - field_reset = 1.
    - Next state is PLAY.
    - Lasts exactly 1 cycle.
  - PLAY
    - Forwards arbitrated pulses.
    - If left_end_on & (pL & ~pR): L pulse still emitted, score_L += 1, next state is POINT_L.
    - Symmetric for right_end_on & (pR & ~pL): score_R += 1, next state is POINT_R.
    - If both end lights read 1 (illegal), left takes priority.
  - POINT_L / POINT_R
    - winner = 01 / 10; L = R = 0; presses ignored.
    - Hold counter counts 0..HOLD_CYCLES−1, then next state is CLEAR.
    - If the updated score == WIN_SCORE, next state is MATCH_OVER immediately instead; no hold.
    - Total point display is HOLD_CYCLES cycles.
  - MATCH_OVER
    - match_over = 1; winner holds the final winner; scores hold; L = R = 0.
    - field_reset = 0.
    - Left only by Reset.
- Score arithmetic:
  - Unsigned, SCORE_W bits.
  - A score cannot exceed WIN_SCORE, because the match ends on reaching it; no wrap possible.
- winner is 00 in CLEAR and PLAY.
- Reset mid-point or mid-match: returns to CLEAR next cycle; scores zeroed; no stale pulses.
- Key held through CLEAR into PLAY:
  - Not a press, because history keeps updating in every state.
  - After Reset, history is 0, so a key already held gives exactly one press in the first PLAY cycle.

Optional Feature:
- Macro: CPU_PLAYER_EN.
- When defined:
  - key_R is ignored.
  - An 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on Reset, advances every cycle) generates the right press.
  - Right press pR = 1 when LFSR[2:0] == 3'b000 and state == PLAY.
  - The LFSR output is treated exactly like an edge-detected press and is arbitrated identically.
- When undefined: no LFSR is instantiated and key_R is used as specified above.

Test Plan:
- Reset held 2 cycles, then released:
  - Cycle after release: field_reset = 1.
  - Next cycle: PLAY, field_reset = 0.
  - scores 0/0, winner = 00, match_over = 0.
- key_L held high 5 cycles in PLAY → exactly one L pulse, R = 0 throughout.
- key_L and key_R rising in the same cycle → L = R = 0 that cycle; scores unchanged.
- left_end_on = 1, single key_L edge:
  - L = 1, score_L 0→1, winner = 01 for 4 cycles.
  - Then field_reset = 1 for 1 cycle, then back to PLAY.
- With score_R = 6, right_end_on = 1, key_R edge:
  - score_R = 7, match_over = 1, winner = 10, held.
  - Further key edges give no pulses.
  - Reset clears everything.
- Reset asserted during the POINT_R hold → next cycle field_reset = 1, scores 0/0, winner = 00.

Source files
------------

// File: rtl/tug_of_war_ctrl.sv
// tug_of_war_ctrl: key edge detection, move arbitration, scoring and match control for the tug-of-war light row.
// Define CPU_PLAYER_EN to replace the right key with an LFSR-driven computer player.
module tug_of_war_ctrl #(
    parameter int SCORE_W     = 3,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               key_L,
    input  logic               key_R,
    input  logic               left_end_on,
    input  logic               right_end_on,
    output logic               L,
    output logic               R,
    output logic               field_reset,
    output logic [SCORE_W-1:0] score_L,
    output logic [SCORE_W-1:0] score_R,
    output logic [1:0]         winner,
    output logic               match_over
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {CLEAR, PLAY, POINT_L, POINT_R, MATCH_OVER} state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d, pt_score;
    logic [HW-1:0]      hold_q, hold_d;
    logic               key_l_q, p_l, p_r, move_l, move_r;

    assign p_l = key_L & ~key_l_q;

`ifdef CPU_PLAYER_EN
    logic [7:0] lfsr_q, lfsr_d;
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign p_r    = (lfsr_q[2:0] == 3'b000) && (state_q == PLAY);
    always_ff @(posedge Clock) lfsr_q <= Reset ? 8'hA5 : lfsr_d;
`else
    logic key_r_q;
    assign p_r = key_R & ~key_r_q;
    always_ff @(posedge Clock) key_r_q <= Reset ? 1'b0 : key_R;
`endif

    assign move_l  = p_l & ~p_r;
    assign move_r  = p_r & ~p_l;
    assign score_L = score_l_q;
    assign score_R = score_r_q;

    always_comb begin
        state_d     = state_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        hold_d      = hold_q;
        pt_score    = (state_q == POINT_L) ? score_l_q : score_r_q;
        L           = 1'b0;
        R           = 1'b0;
        field_reset = 1'b0;
        winner      = 2'b00;
        match_over  = 1'b0;
        if (Reset) begin
            field_reset = 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    field_reset = 1'b1;
                    state_d     = PLAY;
                end
                PLAY: begin
                    L = move_l;
                    R = move_r;
                    // simultaneous presses cancel, so at most one end can score
                    if (left_end_on && move_l) begin
                        score_l_d = score_l_q + 1'b1;
                        state_d   = POINT_L;
                    end else if (right_end_on && move_r) begin
                        score_r_d = score_r_q + 1'b1;
                        state_d   = POINT_R;
                    end
                end
                POINT_L, POINT_R: begin
                    winner = (state_q == POINT_L) ? 2'b01 : 2'b10;
                    if (pt_score == WIN) begin
                        state_d = MATCH_OVER;
                    end else if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = CLEAR;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                MATCH_OVER: begin
                    match_over = 1'b1;
                    winner     = (score_l_q == WIN) ? 2'b01 : 2'b10;
                end
                default: state_d = CLEAR;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= CLEAR;
            score_l_q <= '0;
            score_r_q <= '0;
            hold_q    <= '0;
            key_l_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            hold_q    <= hold_d;
            key_l_q   <= key_L;
        end
    end
endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// tb_tug_of_war_ctrl: random key/end-light stimulus checked against a cycle-level game model.
module tb_tug_of_war_ctrl;
    logic       clk = 1'b0, rst = 1'b1;
    logic       kl = 1'b0, kr = 1'b0, le = 1'b0, re = 1'b0;
    logic       L, R, field_reset, match_over;
    logic [2:0] score_L, score_R;
    logic [1:0] winner;
    int         checks = 0, passed = 0;

    tug_of_war_ctrl dut (
        .Clock(clk), .Reset(rst), .key_L(kl), .key_R(kr),
        .left_end_on(le), .right_end_on(re),
        .L(L), .R(R), .field_reset(field_reset),
        .score_L(score_L), .score_R(score_R),
        .winner(winner), .match_over(match_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    endtask

    // model: scores, who holds a point on display, how long it has shown,
    // whether the field is being cleared and whether the match is decided
    int sl = 0, sr = 0, who = 0, shown = 0, over_cycles = 0;
    bit clearing = 1, over = 0, pk_l = 0, pk_r = 0;

    initial begin
        int el, er, efr, ew, emo;
        bit pl, pr, playing;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst = (cyc > 0 && $urandom_range(0, 299) == 0) || over_cycles > 6;
            if ($urandom_range(0, 2) == 0) kl = ~kl;
            if ($urandom_range(0, 2) == 0) kr = ~kr;
            le = $urandom_range(0, 2) == 0;
            re = $urandom_range(0, 2) == 0;
            #1;
            pl = kl && !pk_l;
            pr = kr && !pk_r;
            playing = !rst && !clearing && who == 0 && !over;
            el  = playing && pl && !pr;
            er  = playing && pr && !pl;
            efr = rst || clearing;
            ew  = rst ? 0 : over ? (sl == 7 ? 1 : 2) : who;
            emo = !rst && over;
            check("L", L, el);
            check("R", R, er);
            check("field_reset", field_reset, efr);
            check("score_L", score_L, sl);
            check("score_R", score_R, sr);
            check("winner", winner, ew);
            check("match_over", match_over, emo);
            if (rst) begin
                sl = 0; sr = 0; who = 0; shown = 0; over = 0; clearing = 1;
                pk_l = 0; pk_r = 0; over_cycles = 0;
            end else begin
                pk_l = kl;
                pk_r = kr;
                if (clearing) clearing = 0;
                else if (over) over_cycles++;
                else if (who != 0) begin
                    if ((who == 1 ? sl : sr) == 7) begin
                        over = 1;
                        who = 0;
                    end else begin
                        shown++;
                        if (shown == 4) begin
                            who = 0;
                            clearing = 1;
                        end
                    end
                end else if (el && le) begin
                    sl++; who = 1; shown = 0;
                end else if (er && re) begin
                    sr++; who = 2; shown = 0;
                end
            end
            @(negedge clk);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
